// File: rtl/clk_timer_ctrl.sv
// clk_timer_ctrl: prescaler timebase with tick, square-wave clk_output and one-shot done.
// TIMER_CTRL_RELOAD_EN: shadowed config writes while running, applied on the next tick.
module clk_timer_ctrl #(
  parameter int CNT_W = 26,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic             clk_input,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic [7:0]       cfg_count,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  output logic             tick,
  output logic             clk_output,
  output logic             done,
  output logic             busy,
  output logic             cfg_err
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] pre, div_reg, div_in;
  logic [7:0] remaining, count_reg, count_in;
  logic mode, active, term, fin, cfg_ok;
`ifdef TIMER_CTRL_RELOAD_EN
  logic [CNT_W-1:0] sh_div;
  logic [7:0] sh_count;
  logic sh_mode, sh_pend;
`endif
  assign div_in = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
  assign count_in = (cfg_count == '0) ? 8'd1 : cfg_count;
  // the HOLD->RUN edge already advances, so each held cycle costs exactly one
  assign active = (state == RUN || state == HOLD) && !hold;
  assign term = active && pre == div_reg - CNT_W'(1);
  assign fin = term && mode && remaining == 8'd1;
  assign cfg_ok = state == IDLE || state == DONE;
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pre <= '0;
      remaining <= 8'd1;
      div_reg <= CNT_W'(DEFAULT_DIV);
      mode <= 1'b0;
      count_reg <= 8'd1;
      tick <= 1'b0;
      clk_output <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      cfg_err <= 1'b0;
`ifdef TIMER_CTRL_RELOAD_EN
      sh_div <= CNT_W'(DEFAULT_DIV);
      sh_mode <= 1'b0;
      sh_count <= 8'd1;
      sh_pend <= 1'b0;
`endif
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      cfg_err <= 1'b0;
      if (stop) begin
        state <= IDLE;
        pre <= '0;
        clk_output <= 1'b0;
        busy <= 1'b0;
      end else if (start) begin
        state <= RUN;
        pre <= '0;
        remaining <= count_reg;
        busy <= 1'b1;
      end else begin
        if (state == RUN && hold) state <= HOLD;
        else if (state == HOLD && !hold) state <= RUN;
        if (active) pre <= term ? '0 : pre + CNT_W'(1);
        if (term) begin
          tick <= 1'b1;
          clk_output <= ~clk_output;
          if (mode) remaining <= remaining - 8'd1;
        end
        if (fin) begin
          state <= DONE;
          done <= 1'b1;
          busy <= 1'b0;
        end
        if (cfg_we && cfg_ok) begin
          div_reg <= div_in;
          mode <= cfg_mode;
          count_reg <= count_in;
`ifdef TIMER_CTRL_RELOAD_EN
          sh_pend <= 1'b0;
        end else if (cfg_we) begin
          sh_div <= div_in;
          sh_mode <= cfg_mode;
          sh_count <= count_in;
          sh_pend <= 1'b1;
        end
        // a write landing on the tick edge is transferred directly
        if (term && (sh_pend || cfg_we)) begin
          div_reg <= cfg_we ? div_in : sh_div;
          mode <= cfg_we ? cfg_mode : sh_mode;
          count_reg <= cfg_we ? count_in : sh_count;
          sh_pend <= 1'b0;
        end
`else
        end else if (cfg_we) cfg_err <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_clk_timer_ctrl.sv
// tb_clk_timer_ctrl: directed and random stimulus against a deadline-based timer model,
// with tick and cfg_err events checked by a scoreboard monitor on the falling edge.
module tb_clk_timer_ctrl;
  localparam int W = 26;
  localparam int DEF = 50000000;
  logic clk_input = 1'b0, reset = 1'b1;
  logic cfg_we = 1'b0, cfg_mode = 1'b0, start = 1'b0, stop = 1'b0, hold = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic [7:0] cfg_count = '0;
  logic tick, clk_output, done, busy, cfg_err;
  clk_timer_ctrl #(.CNT_W(W), .DEFAULT_DIV(DEF)) dut (
    .clk_input(clk_input), .reset(reset), .cfg_we(cfg_we), .cfg_div(cfg_div),
    .cfg_mode(cfg_mode), .cfg_count(cfg_count), .start(start), .stop(stop),
    .hold(hold), .tick(tick), .clk_output(clk_output), .done(done),
    .busy(busy), .cfg_err(cfg_err)
  );
  always #5 clk_input = ~clk_input;
  typedef struct {int e; logic c; logic d;} rec_t;
  rec_t tq[$];
  int eq[$];
  int n_chk = 0, n_fail = 0, m_edge = 0;
  int m_div, m_cnt, m_left, m_next;
  logic m_run, m_busy, m_clk, m_mode, m_pend, chk_en = 1'b0;
  int s_div, s_cnt;
  logic s_mode;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at model edge %0d: got %0h expected %0h", nm, m_edge, act, exp);
    end
  endtask
  task automatic model_reset();
    m_run = 0; m_busy = 0; m_clk = 0; m_mode = 0; m_pend = 0;
    m_div = DEF; m_cnt = 1; m_left = 1; m_next = 0;
    tq.delete();
    eq.delete();
  endtask
  // one clock edge: drive inputs, then advance the reference model for that edge
  task automatic step(input logic st, input logic sp, input logic hd, input logic we,
                      input int dv, input logic md, input int ct);
    int k;
    logic fin;
    start = st; stop = sp; hold = hd; cfg_we = we;
    cfg_div = W'(dv); cfg_mode = md; cfg_count = 8'(ct);
    @(posedge clk_input);
    k = m_edge + 1;
    m_edge = k;
    if (sp) begin
      m_run = 0; m_busy = 0; m_clk = 0;
    end else if (st) begin
      m_run = 1; m_busy = 1; m_next = k + m_div; m_left = m_cnt;
    end else begin
      if (we && !m_run) begin
        m_div = (dv == 0) ? 1 : dv; m_mode = md; m_cnt = (ct == 0) ? 1 : ct; m_pend = 0;
      end else if (we) begin
`ifdef TIMER_CTRL_RELOAD_EN
        s_div = (dv == 0) ? 1 : dv; s_mode = md; s_cnt = (ct == 0) ? 1 : ct; m_pend = 1;
`else
        eq.push_back(k);
`endif
      end
      if (m_run) begin
        if (hd) m_next++;
        else if (k == m_next) begin
          m_clk = !m_clk;
          fin = m_mode && m_left == 1;
          if (m_mode) m_left--;
          if (m_pend) begin
            m_div = s_div; m_mode = s_mode; m_cnt = s_cnt; m_pend = 0;
          end
          m_next = k + m_div;
          if (fin) begin
            m_run = 0; m_busy = 0;
          end
          tq.push_back('{k, m_clk, fin});
        end
      end
    end
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic cfg(input int dv, input logic md, input int ct);
    step(0, 0, 0, 1, dv, md, ct);
  endtask
  task automatic reset_mid();
    #6 reset = 1'b1;
    #1 check("async_reset_outputs", {27'b0, tick, clk_output, done, busy, cfg_err}, 32'd0);
    model_reset();
    reset = 1'b0;
  endtask
  logic exp_t, exp_e;
  rec_t r;
  always @(negedge clk_input) begin
    if (chk_en && !reset) begin
      exp_t = tq.size() > 0 && tq[0].e == m_edge;
      if (tick || exp_t) check("tick", tick, exp_t);
      if (exp_t) begin
        r = tq.pop_front();
        check("done_on_tick", done, r.d);
      end else if (done) check("done_without_tick", done, 0);
      exp_e = eq.size() > 0 && eq[0] == m_edge;
      if (cfg_err || exp_e) check("cfg_err", cfg_err, exp_e);
      if (exp_e) void'(eq.pop_front());
      check("busy", busy, m_busy);
      check("clk_output", clk_output, m_clk);
    end
  end
  initial begin
    model_reset();
    repeat (3) @(posedge clk_input);
    #1 check("reset_state_in_reset", {27'b0, tick, clk_output, done, busy, cfg_err}, 32'd0);
    reset = 1'b0;
    #1 check("reset_state_after_release", {27'b0, tick, clk_output, done, busy, cfg_err}, 32'd0);
    chk_en = 1'b1;
    cfg(4, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(20);
    step(0, 1, 0, 0, 0, 0, 0);
    cfg(3, 1, 2);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(26);
    cfg(5, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(7);
    repeat (7) step(0, 0, 1, 0, 0, 0, 0);
    idle(15);
    step(0, 1, 0, 0, 0, 0, 0);
    cfg(4, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(3);
    step(1, 1, 0, 0, 0, 0, 0);
    idle(5);
    cfg(0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(6);
    reset_mid();
    cfg(4, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(5);
    cfg(8, 0, 0);
    idle(30);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 12,
           $urandom_range(0, 99) < 8, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)));
    step(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    check("tick_queue_drained", tq.size(), 0);
    check("err_queue_drained", eq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_timer_ctrl.md
# clk_timer_ctrl

Programmable timebase controller that sequences a single prescaler counter on the 100 MHz board clock. It replaces fixed-period dividers: software or front-panel logic loads a divide value, then starts, holds or stops the timer. The block emits a one-cycle `tick` enable, a square-wave `clk_output`, and an optional one-shot `done` after a programmed number of ticks. It sits between the user controls (buttons/switch debouncers) and the display/counter logic that consumes `tick`.

## Interface
- `CNT_W`, 26: prescaler and divide-register width.
- `DEFAULT_DIV`, 50000000: divide value loaded at reset (1 Hz `clk_output` at 100 MHz).
- `clk_input`  in  1  100 MHz system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset; one clock, no other clock domains.
- `cfg_we`  in  1  config write strobe; samples `cfg_div`, `cfg_mode` and `cfg_count`.
- `cfg_div`  in  CNT_W  tick period in clock cycles; 0 is coerced to 1.
- `cfg_mode`  in  1  0 = periodic, 1 = one-shot.
- `cfg_count`  in  8  ticks per one-shot run; 0 is coerced to 1.
- `start`  in  1  start or restart pulse.
- `stop`  in  1  abort to IDLE.
- `hold`  in  1  level; freezes the prescaler while high.
- `tick`  out  1  one-cycle period pulse; reset 0.
- `clk_output`  out  1  toggles on every tick; reset 0.
- `done`  out  1  one-cycle pulse on the final one-shot tick; reset 0.
- `busy`  out  1  high in RUN or HOLD; reset 0.
- `cfg_err`  out  1  one-cycle pulse when a `cfg_we` is rejected; reset 0.

## Operation
- **States:** IDLE (reset state), RUN, HOLD, DONE.
- **Reset values:** prescaler = 0, remaining = 1, div_reg = DEFAULT_DIV, mode = periodic, all outputs 0.
- **Input priority** per edge: `stop` > `start` > `hold` > `cfg_we`.
- **stop:** from any state → IDLE. Clears the prescaler and `clk_output`. No `tick` or `done` that cycle, even if the terminal count coincides.
- **start** in IDLE or DONE → RUN. Prescaler = 0, remaining = count_reg.
- **start** in RUN or HOLD: restart. Same load, destination RUN; `clk_output` is not cleared.
- **RUN:**
  - If prescaler == div_reg−1: prescaler ← 0, `tick` asserts next cycle, `clk_output` toggles.
  - Otherwise prescaler increments.
- **One-shot:** each tick decrements remaining. The tick that takes remaining from 1 to 0 also asserts `done` in the same cycle, and the state goes to DONE.
- **HOLD:**
  - RUN with `hold`=1 → HOLD; the prescaler freezes with no tick.
  - `hold`=0 → RUN; counting resumes from the frozen value.
  - `hold` in IDLE or DONE has no effect.
- **DONE:** `busy`=0, `clk_output` keeps its last value; leaves only on `start` or `stop`.
- **Config writes:**
  - Accepted in IDLE or DONE: registers update on that edge.
  - In RUN or HOLD, behaviour depends on `TIMER_CTRL_RELOAD_EN` (see Configuration).
- **Arithmetic:** prescaler and comparison are CNT_W-bit unsigned. div_reg ≥ 1 always, so no wrap beyond div_reg−1.

## Timing
- Start sampled at edge E0: `busy` is high after E0.
- First `tick` is high during the cycle after edge E_div. Subsequent ticks are exactly div_reg cycles apart.
- div_reg = 1: `tick` is high every cycle while in RUN; `clk_output` = clk/2.
- `done` coincides with the final `tick`; `busy` falls on the same edge that raises `done`.
- Hold latency: `hold` sampled high at edge Eh means no prescaler advance at Eh. Each held cycle extends the tick period by one.
- `cfg_err` is high the cycle after the rejected write.
- Asserting `reset` mid-run forces all outputs to 0 immediately (asynchronous), with no trailing tick.

## Configuration
- **`TIMER_CTRL_RELOAD_EN` defined:**
  - `cfg_we` in RUN or HOLD writes shadow registers; `cfg_err` stays 0.
  - Shadows transfer to div_reg/mode/count_reg on the next tick edge. Remaining reloads only at the next `start`.
  - A newer write before the transfer overwrites the shadow.
  - Write and tick on the same edge: the transfer uses the new value.
- **Undefined:**
  - `cfg_we` in RUN or HOLD is ignored and pulses `cfg_err`.
  - No shadow registers are built.

## Test plan
- Reset, then `start` with default div reduced by a `cfg_we` with `cfg_div`=4, periodic → `tick` every 4 cycles, first 4 cycles after start; `clk_output` period 8 cycles.
- `cfg_div`=3, `cfg_mode`=1, `cfg_count`=2, start → ticks at +3 and +6; `done` with the second tick; `busy` low after; no third tick in 20 cycles.
- div=5, run; assert `hold` for 7 cycles mid-period → tick interval across the hold = 12 cycles; prescaler value preserved.
- div=4; assert `stop` on the edge where prescaler = 3 → no tick, IDLE, `clk_output`=0. `start` and `stop` asserted together → stays IDLE.
- `cfg_div`=0 → behaves as div 1, with `tick` continuously high in RUN. Async `reset` mid-run → all outputs 0 within the same cycle.
- `cfg_we` `cfg_div`=8 during RUN at div 4:
  - With the macro: the old period finishes, then 8-cycle ticks follow.
  - Without the macro: `cfg_err` pulses and the period stays 4.
